// File: rtl/alu_mc_if.sv
// Operation/result handshake bus between the execute stage and alu_mc.
// The slave modport is the ALU side; the master modport is the issuing side.
interface alu_mc_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OP_W = 6
) ();
    logic            in_valid_i;
    logic            in_ready_o;
    logic [OP_W-1:0] alu_op_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;
    logic            branch_taken_o;
    logic [XLEN-1:0] target_o;
    logic            illegal_o;

    modport slave (
        input  in_valid_i, alu_op_i, op_a_i, op_b_i, imm_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, branch_taken_o, target_o, illegal_o
    );

    modport master (
        output in_valid_i, alu_op_i, op_a_i, op_b_i, imm_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, branch_taken_o, target_o, illegal_o
    );
endinterface

// File: rtl/alu_mc.sv
// Handshaked multi-cycle integer ALU with branch resolution. Every result is registered;
// shifts go through an iterative shifter moving at most SHIFT_STEP bits per cycle.
module alu_mc #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1,
    parameter int unsigned OP_W       = 6
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    alu_mc_if.slave bus
);
    localparam int unsigned SH_W = $clog2(XLEN);
    localparam logic [SH_W:0] STEP = (SH_W + 1)'(SHIFT_STEP);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
    typedef enum logic [1:0] {ShSll, ShSrl, ShSra} sh_kind_e;

    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_result, w_result_nxt, r_target, w_target_nxt, r_sh_val, w_sh_val_nxt;
    logic            r_taken, w_taken_nxt, r_illegal, w_illegal_nxt;
    logic [SH_W:0]   r_rem, w_rem_nxt;
    sh_kind_e        r_kind, w_kind_nxt;

    logic [XLEN-1:0] w_a, w_b, w_imm, w_pc, w_sum, w_pc_imm, w_pc4;
    logic [XLEN-1:0] w_dec_res, w_dec_tgt;
    logic            w_dec_taken, w_dec_ill, w_dec_shift, w_dec_sh_imm;
    sh_kind_e        w_dec_kind, w_sh_kind;
    logic [SH_W:0]   w_dec_shamt, w_sh_req, w_sh_amt;
    logic [XLEN-1:0] w_sh_in, w_sh_out;
    logic            w_in_ready, w_accept;
    int unsigned     w_op;

    assign w_a      = bus.op_a_i;
    assign w_b      = bus.op_b_i;
    assign w_imm    = bus.imm_i;
    assign w_pc     = bus.pc_i;
    assign w_op     = 32'(bus.alu_op_i);
    assign w_sum    = w_a + w_imm;
    assign w_pc_imm = w_pc + w_imm;
    assign w_pc4    = w_pc + XLEN'(4);

    always_comb begin
        w_dec_res    = '0;
        w_dec_tgt    = '0;
        w_dec_taken  = 1'b0;
        w_dec_ill    = 1'b0;
        w_dec_shift  = 1'b0;
        w_dec_sh_imm = 1'b0;
        w_dec_kind   = ShSll;
        case (w_op)
            1, 2, 3, 5, 6, 8, 18, 19, 20: w_dec_res = w_sum;
            4, 7, 21: begin
                if (XLEN == 64) w_dec_res = w_sum;
                else            w_dec_ill = 1'b1;
            end
            9:  begin w_dec_shift = 1'b1; w_dec_sh_imm = 1'b1; w_dec_kind = ShSll; end
            10: w_dec_res = XLEN'($signed(w_a) < $signed(w_imm));
            11: w_dec_res = XLEN'(w_a < w_imm);
            12: w_dec_res = w_a ^ w_imm;
            13: begin w_dec_shift = 1'b1; w_dec_sh_imm = 1'b1; w_dec_kind = ShSrl; end
            14: begin w_dec_shift = 1'b1; w_dec_sh_imm = 1'b1; w_dec_kind = ShSra; end
            15: w_dec_res = w_a | w_imm;
            16: w_dec_res = w_a & w_imm;
            17: w_dec_res = w_pc_imm;
            32: w_dec_res = w_imm;
            22: w_dec_res = w_a + w_b;
            23: w_dec_res = w_a - w_b;
            24: begin w_dec_shift = 1'b1; w_dec_kind = ShSll; end
            25: w_dec_res = XLEN'($signed(w_a) < $signed(w_b));
            26: w_dec_res = XLEN'(w_a < w_b);
            27: w_dec_res = w_a ^ w_b;
            28: begin w_dec_shift = 1'b1; w_dec_kind = ShSrl; end
            29: begin w_dec_shift = 1'b1; w_dec_kind = ShSra; end
            30: w_dec_res = w_a | w_b;
            31: w_dec_res = w_a & w_b;
            33: begin w_dec_taken = (w_a == w_b);                   w_dec_tgt = w_pc_imm; end
            34: begin w_dec_taken = (w_a != w_b);                   w_dec_tgt = w_pc_imm; end
            35: begin w_dec_taken = ($signed(w_a) < $signed(w_b));  w_dec_tgt = w_pc_imm; end
            36: begin w_dec_taken = ($signed(w_a) >= $signed(w_b)); w_dec_tgt = w_pc_imm; end
            37: begin w_dec_taken = (w_a < w_b);                    w_dec_tgt = w_pc_imm; end
            38: begin w_dec_taken = (w_a >= w_b);                   w_dec_tgt = w_pc_imm; end
            39: begin w_dec_taken = 1'b1; w_dec_tgt = {w_sum[XLEN-1:1], 1'b0}; w_dec_res = w_pc4; end
            40: begin w_dec_taken = 1'b1; w_dec_tgt = w_pc_imm; w_dec_res = w_pc4; end
            default: w_dec_ill = 1'b1;
        endcase
    end

    assign w_dec_shamt = w_dec_sh_imm ? {1'b0, w_imm[SH_W-1:0]} : {1'b0, w_b[SH_W-1:0]};

    // One shared step-limited shifter: fed by the operand on accept, by the partial result in StShift.
    assign w_sh_in   = (r_state == StShift) ? r_sh_val : w_a;
    assign w_sh_kind = (r_state == StShift) ? r_kind : w_dec_kind;
    assign w_sh_req  = (r_state == StShift) ? r_rem : w_dec_shamt;
    assign w_sh_amt  = (w_sh_req > STEP) ? STEP : w_sh_req;

    always_comb begin
        w_sh_out = w_sh_in;
        case (w_sh_kind)
            ShSll:   w_sh_out = w_sh_in << w_sh_amt;
            ShSrl:   w_sh_out = w_sh_in >> w_sh_amt;
            default: w_sh_out = XLEN'($signed(w_sh_in) >>> w_sh_amt);
        endcase
    end

    assign w_in_ready = (r_state == StIdle) || ((r_state == StDone) && bus.out_ready_i);
    assign w_accept   = bus.in_valid_i && w_in_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_result_nxt  = r_result;
        w_target_nxt  = r_target;
        w_taken_nxt   = r_taken;
        w_illegal_nxt = r_illegal;
        w_sh_val_nxt  = r_sh_val;
        w_rem_nxt     = r_rem;
        w_kind_nxt    = r_kind;
        case (r_state)
            StShift: begin
                if (r_rem > STEP) begin
                    w_sh_val_nxt = w_sh_out;
                    w_rem_nxt    = r_rem - STEP;
                end else begin
                    w_state_nxt   = StDone;
                    w_result_nxt  = w_sh_out;
                    w_target_nxt  = '0;
                    w_taken_nxt   = 1'b0;
                    w_illegal_nxt = 1'b0;
                end
            end
            default: begin
                if (w_accept) begin
                    // The accept edge already performs the first step of a long shift.
                    if (w_dec_shift && (w_dec_shamt > STEP)) begin
                        w_state_nxt  = StShift;
                        w_sh_val_nxt = w_sh_out;
                        w_rem_nxt    = w_dec_shamt - STEP;
                        w_kind_nxt   = w_dec_kind;
                    end else begin
                        w_state_nxt   = StDone;
                        w_result_nxt  = w_dec_shift ? w_sh_out : w_dec_res;
                        w_target_nxt  = w_dec_tgt;
                        w_taken_nxt   = w_dec_taken;
                        w_illegal_nxt = w_dec_ill;
                    end
                end else if ((r_state == StDone) && bus.out_ready_i) begin
                    w_state_nxt = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= StIdle;
            r_result  <= '0;
            r_target  <= '0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
            r_sh_val  <= '0;
            r_rem     <= '0;
            r_kind    <= ShSll;
        end else begin
            r_state   <= w_state_nxt;
            r_result  <= w_result_nxt;
            r_target  <= w_target_nxt;
            r_taken   <= w_taken_nxt;
            r_illegal <= w_illegal_nxt;
            r_sh_val  <= w_sh_val_nxt;
            r_rem     <= w_rem_nxt;
            r_kind    <= w_kind_nxt;
        end
    end

    assign bus.in_ready_o     = w_in_ready;
    assign bus.out_valid_o    = (r_state == StDone);
    assign bus.result_o       = r_result;
    assign bus.target_o       = r_target;
    assign bus.branch_taken_o = r_taken;
    assign bus.illegal_o      = r_illegal;
endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed checks of alu_mc (XLEN=32, SHIFT_STEP=8) against an
// instruction-level reference model of results, targets and latency.
module tb_alu_mc;
    localparam int unsigned XLEN = 32;
    localparam int unsigned STEP = 8;
    localparam int unsigned OP_W = 6;

    typedef struct {
        logic [31:0] res;
        logic [31:0] tgt;
        logic        taken;
        logic        ill;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t e_cur;

    always #5 clk = ~clk;

    alu_mc_if #(.XLEN(XLEN), .OP_W(OP_W)) bus ();

    alu_mc #(.XLEN(XLEN), .SHIFT_STEP(STEP), .OP_W(OP_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(int op, logic [31:0] a, logic [31:0] b,
                                   logic [31:0] imm, logic [31:0] pc);
        exp_t e;
        int   sh;
        e.res = 0; e.tgt = 0; e.taken = 0; e.ill = 0; e.lat = 1;
        sh = 0;
        case (op)
            1, 2, 3, 5, 6, 8, 18, 19, 20: e.res = a + imm;
            9:  begin sh = int'(imm % 32); e.res = a << sh; end
            10: e.res = ($signed(a) < $signed(imm)) ? 1 : 0;
            11: e.res = (a < imm) ? 1 : 0;
            12: e.res = a ^ imm;
            13: begin sh = int'(imm % 32); e.res = a >> sh; end
            14: begin sh = int'(imm % 32); e.res = $signed(a) >>> sh; end
            15: e.res = a | imm;
            16: e.res = a & imm;
            17: e.res = pc + imm;
            32: e.res = imm;
            22: e.res = a + b;
            23: e.res = a - b;
            24: begin sh = int'(b % 32); e.res = a << sh; end
            25: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            26: e.res = (a < b) ? 1 : 0;
            27: e.res = a ^ b;
            28: begin sh = int'(b % 32); e.res = a >> sh; end
            29: begin sh = int'(b % 32); e.res = $signed(a) >>> sh; end
            30: e.res = a | b;
            31: e.res = a & b;
            33: begin e.taken = (a == b); e.tgt = pc + imm; end
            34: begin e.taken = (a != b); e.tgt = pc + imm; end
            35: begin e.taken = ($signed(a) < $signed(b)); e.tgt = pc + imm; end
            36: begin e.taken = ($signed(a) >= $signed(b)); e.tgt = pc + imm; end
            37: begin e.taken = (a < b); e.tgt = pc + imm; end
            38: begin e.taken = (a >= b); e.tgt = pc + imm; end
            39: begin e.taken = 1; e.tgt = (a + imm) & 32'hFFFF_FFFE; e.res = pc + 4; end
            40: begin e.taken = 1; e.tgt = pc + imm; e.res = pc + 4; end
            default: e.ill = 1;  // includes RV64-only 4, 7, 21
        endcase
        if (sh > 0) e.lat = (sh + int'(STEP) - 1) / int'(STEP);
        return e;
    endfunction

    task automatic issue(int op, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                         logic [31:0] pc, int hold);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("in_ready_offer", 64'(bus.in_ready_o), 64'd1);
        bus.alu_op_i    = OP_W'(op);
        bus.op_a_i      = a;
        bus.op_b_i      = b;
        bus.imm_i       = imm;
        bus.pc_i        = pc;
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        e_cur = model(op, a, b, imm, pc);
        @(posedge clk);
        #1;
        // Inputs change after accept; the captured op must not be affected.
        bus.in_valid_i  = 1'b0;
        bus.alu_op_i    = OP_W'($urandom);
        bus.op_a_i      = $urandom;
        bus.op_b_i      = $urandom;
        bus.imm_i       = $urandom;
        bus.pc_i        = $urandom;
        bus.out_ready_i = (hold == 0);
    endtask

    task automatic collect(string tag, int hold);
        int lat = 1;
        while (!bus.out_valid_o && lat < 200) begin
            check_eq({tag, "_busy_ready"}, 64'(bus.in_ready_o), 64'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(e_cur.lat));
        check_eq({tag, "_result"}, 64'(bus.result_o), 64'(e_cur.res));
        check_eq({tag, "_target"}, 64'(bus.target_o), 64'(e_cur.tgt));
        check_eq({tag, "_taken"}, 64'(bus.branch_taken_o), 64'(e_cur.taken));
        check_eq({tag, "_illegal"}, 64'(bus.illegal_o), 64'(e_cur.ill));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, 64'(bus.out_valid_o), 64'd1);
            check_eq({tag, "_hold_result"}, 64'(bus.result_o), 64'(e_cur.res));
            check_eq({tag, "_hold_target"}, 64'(bus.target_o), 64'(e_cur.tgt));
            check_eq({tag, "_hold_ready"}, 64'(bus.in_ready_o), 64'd0);
        end
        bus.out_ready_i = 1'b1;
    endtask

    task automatic do_op(int op, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                         logic [31:0] pc, int hold, string tag);
        issue(op, a, b, imm, pc, hold);
        collect(tag, hold);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, a, b, imm;
        int          op;
        bus.in_valid_i  = 1'b0;
        bus.alu_op_i    = '0;
        bus.op_a_i      = '0;
        bus.op_b_i      = '0;
        bus.imm_i       = '0;
        bus.pc_i        = '0;
        bus.out_ready_i = 1'b1;
        #12;
        check_eq("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        check_eq("rst_result", 64'(bus.result_o), 64'd0);
        check_eq("rst_target", 64'(bus.target_o), 64'd0);
        check_eq("rst_taken", 64'(bus.branch_taken_o), 64'd0);
        check_eq("rst_illegal", 64'(bus.illegal_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(22, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, "add_wrap");
        check_eq("add_wrap_const", 64'(bus.result_o), 64'd0);
        do_op(23, 32'd5, 32'd7, 0, 0, 0, "sub_b2b");
        check_eq("sub_b2b_const", 64'(bus.result_o), 64'hFFFF_FFFE);
        check_eq("sub_b2b_ready", 64'(bus.in_ready_o), 64'd1);
        do_op(25, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, "slt");
        check_eq("slt_const", 64'(bus.result_o), 64'd1);
        do_op(26, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, "sltu");
        check_eq("sltu_const", 64'(bus.result_o), 64'd0);
        do_op(29, 32'h8000_0000, 32'd31, 0, 0, 0, "sra31");
        check_eq("sra31_const", 64'(bus.result_o), 64'hFFFF_FFFF);
        do_op(13, 32'h1234_5678, 0, 32'd0, 0, 0, "srli0");
        check_eq("srli0_const", 64'(bus.result_o), 64'h1234_5678);
        do_op(24, 32'd1, 32'h25, 0, 0, 0, "sll_b25");
        check_eq("sll_b25_const", 64'(bus.result_o), 64'h20);
        do_op(37, 32'd1, 32'd2, 32'hFFFF_FFF8, 32'h100, 0, "bltu");
        check_eq("bltu_const", 64'(bus.target_o), 64'hF8);
        do_op(39, 32'h203, 0, 32'd0, 32'h40, 0, "jalr");
        check_eq("jalr_const_tgt", 64'(bus.target_o), 64'h202);
        check_eq("jalr_const_res", 64'(bus.result_o), 64'h44);
        do_op(40, 0, 0, 32'h10, 32'h80, 0, "jal");
        do_op(33, 32'd9, 32'd9, 32'h20, 32'h200, 0, "beq");
        for (int s = 7; s <= 17; s++) do_op(9, 32'hF0F0_1234, 0, 32'(s), 0, 0, "slli_edge");
        do_op(31, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 5, "bp_and");
        do_op(22, 32'd10, 32'd20, 0, 0, 0, "after_bp");
        do_op(45, 32'd1, 32'd2, 32'd3, 32'd4, 0, "ill45");
        check_eq("ill45_const", 64'(bus.illegal_o), 64'd1);
        do_op(4, 32'h100, 0, 32'd8, 0, 0, "ld_rv32");
        do_op(0, 32'h100, 0, 32'd8, 0, 0, "op0");

        // Reset while a long shift is in flight.
        issue(29, 32'h8000_0000, 32'd31, 0, 0, 0);
        check_eq("mid_shift_valid", 64'(bus.out_valid_o), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_shift_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("rst_shift_ready", 64'(bus.in_ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_shift_ready", 64'(bus.in_ready_o), 64'd1);
        check_eq("rel_shift_valid", 64'(bus.out_valid_o), 64'd0);

        // Reset while a result is held under backpressure.
        issue(22, 32'd3, 32'd4, 0, 0, 1);
        check_eq("done_valid", 64'(bus.out_valid_o), 64'd1);
        check_eq("done_result", 64'(bus.result_o), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_done_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("rst_done_result", 64'(bus.result_o), 64'd0);
        check_eq("rst_done_ready", 64'(bus.in_ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        do_op(23, 32'd100, 32'd1, 0, 0, 0, "post_rst");

        for (int n = 0; n < 250; n++) begin
            op  = int'($urandom_range(0, 47));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            r   = $urandom;
            imm = ($urandom_range(0, 1) == 0) ? {{20{r[11]}}, r[11:0]} : r;
            do_op(op, a, b, imm, $urandom, ($urandom_range(0, 3) == 0) ? 2 : 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
